mem_access_unit: RTL
====================

Name: mem_access_unit

Overview:
- Multi-cycle, parametrised successor to the combinational MEM-stage load/store logic.
- Accepts one load/store per start pulse and drives a req/ack data-memory bus with aligned addresses and byte enables.
- Splits misaligned accesses into two bus beats, sign- or zero-extends loads and reports bus timeout or misalignment faults.
- Sits between EX/MEM pipeline register and data memory; busy stalls the pipeline.

Parameters:
- XLEN, 32, data/address width; legal values 32 or 64.
- ALLOW_MISALIGNED, 1, 1 = split line-crossing accesses into two beats; 0 = fault without bus activity.
- TIMEOUT, 16, max cycles mreq may wait for ack before bus error; 0 disables timeout.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation valid; sampled only in IDLE.
- mem_read  in  1  load.
- mem_write  in  1  store.
- is_signed  in  1  sign-extend load result.
- inst_size  in  2  00 byte, 01 half, 10 word, 11 double (legal only when XLEN=64).
- address  in  XLEN  byte address.
- write_data  in  XLEN  store data, LSB-justified.
- busy  out  1  unit not IDLE; pipeline stall.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done: fault occurred.
- err_code  out  2  00 none, 01 misaligned, 10 timeout, 11 illegal op.
- read_data  out  XLEN  extended load result, registered.
- mreq  out  1  bus request.
- write  out  1  bus write, qualified by mreq.
- addr  out  XLEN  aligned bus address, low log2(XLEN/8) bits zero.
- byte_en  out  XLEN/8  active byte lanes.
- wr_data  out  XLEN  lane-aligned store data.
- rd_data  in  XLEN  bus read data, valid with ack.
- ack  in  1  bus beat complete.

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, err, mreq and write = 0. err_code, read_data, addr, byte_en and wr_data = 0. A beat in flight is abandoned, with no done.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - start=1 with exactly one of mem_read/mem_write, legal size -> BEAT0.
  - Both or neither of mem_read/mem_write, or size 11 with XLEN=32 -> RESP, err_code=11.
  - Line-crossing access with ALLOW_MISALIGNED=0 -> RESP, err_code=01.
  - Operands are latched at start; later input changes are ignored until the next IDLE.
- Address arithmetic:
  - NB = XLEN/8; off = address mod NB; n = 1<<inst_size bytes; base = address - off.
  - Line-crossing when off+n > NB.
  - mask = ((1<<n)-1) << off, computed NB+NB bits wide.
- BEAT0:
  - mreq=1, addr=base, byte_en=mask[NB-1:0], wr_data=write_data<<(8*off), write=mem_write.
  - Outputs are held stable until ack.
  - On ack: load data captured; line-crossing -> BEAT1, else -> RESP.
- BEAT1:
  - addr = base+NB, modulo 2^XLEN (wraps to 0 at top of address space).
  - byte_en=mask[2NB-1:NB], wr_data=write_data>>(8*(NB-off)).
  - On ack -> RESP.
- mreq drops for at least the cycle after each ack; the bus sees exactly one request per beat.
- Timeout: a counter resets on beat entry and counts cycles with mreq=1 and ack=0. Reaching TIMEOUT -> mreq=0, RESP, err_code=10; any remaining beat is skipped.
- Load assembly:
  - Combine beat0 bytes [NB-1:off] with beat1 bytes [off+n-NB-1:0].
  - Take n bytes and sign-extend (is_signed) or zero-extend to XLEN.
- RESP:
  - done=1 and busy=1 for exactly one cycle, then IDLE.
  - read_data updates at done: the assembled load value, or 0 for stores and any error. It holds until the next done.
  - err=1 iff err_code≠00.
- Latency: start sampled at edge N; mreq high from N+1.
  - Aligned access with zero-wait ack: done at N+2.
  - Split access with zero-wait acks: done at N+4, since mreq drops for one cycle between beats.
  - Fault detected in IDLE: done at N+1.
- start while busy is ignored (no queueing). The ack input is ignored outside BEAT0/BEAT1.

Test Plan:
- XLEN=32. Signed LB at 0x1003, rd_data=0x80112233, ack same cycle -> addr 0x1000, byte_en 1000; done at N+2 with read_data 0xFFFFFF80. Unsigned repeat -> 0x00000080.
- SH 0xBEEF at 0x1003, ALLOW_MISALIGNED=1:
  - beat0: addr 0x1000, byte_en 1000, wr_data 0xEF000000.
  - beat1: addr 0x1004, byte_en 0001, wr_data 0x000000BE.
  - Then done with err=0 and read_data=0.
- Signed LW at 0x2002, beat0 rd_data 0xAABB0000, beat1 rd_data 0x0000CCDD -> read_data 0xCCDDAABB. Same with ALLOW_MISALIGNED=0 -> no mreq, done at N+1, err_code 01.
- Load at 0x100, ack never asserted, TIMEOUT=16 -> mreq high exactly 16 cycles, then done with err_code 10.
- Illegal ops: start with mem_read=mem_write=1 -> err_code 11. inst_size 11 at XLEN=32 -> err_code 11. Neither case asserts mreq.
- Reset and wrap:
  - rst pulsed mid-BEAT1 -> all outputs 0 asynchronously, no done; a new start afterwards completes normally.
  - XLEN=64. LD at 0xFFFF_FFFF_FFFF_FFFC -> beat1 addr 0x0.

Source files
------------

// File: rtl/mem_access_unit.sv
// Multi-cycle load/store unit for the MEM stage: drives a req/ack data bus, splits
// line-crossing accesses into two beats, extends load data and reports faults.
module mem_access_unit #(
  parameter int XLEN             = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1,
  parameter int TIMEOUT          = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              is_signed,
  input  logic [1:0]        inst_size,
  input  logic [XLEN-1:0]   address,
  input  logic [XLEN-1:0]   write_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [XLEN-1:0]   read_data,
  output logic              mreq,
  output logic              write,
  output logic [XLEN-1:0]   addr,
  output logic [XLEN/8-1:0] byte_en,
  output logic [XLEN-1:0]   wr_data,
  input  logic [XLEN-1:0]   rd_data,
  input  logic              ack
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT != 0);
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  state_t            state_q, state_d;
  logic              mreq_q, mreq_d, write_q, write_d;
  logic [XLEN-1:0]   addr_q, addr_d, wr_data_q, wr_data_d, read_data_q, read_data_d;
  logic [NB-1:0]     byte_en_q, byte_en_d;
  logic [1:0]        err_code_q, err_code_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [OFFW-1:0]   off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              sgn_q, sgn_d, ld_q, ld_d, cross_q, cross_d;
  logic [XLEN-1:0]   base_q, base_d, wdata_q, wdata_d, buf0_q, buf0_d;
  logic [NB-1:0]     mask_hi_q, mask_hi_d;

  logic [OFFW-1:0]   off_in;
  logic [XLEN-1:0]   base_in;
  logic [2*NB-1:0]   ones_in, mask_in;
  logic              cross_in, illegal_in;
  logic [OFFW:0]     rem;

  // Aligns the (possibly two-beat) raw bus data, keeps n bytes and extends them.
  function automatic logic [XLEN-1:0] load_extend(input logic [2*XLEN-1:0] raw,
                                                  input logic [OFFW-1:0]   o,
                                                  input logic [1:0]        sz,
                                                  input logic              sgn);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = XLEN'(raw >> {o, 3'b000});
    case (sz)
      2'b00: begin
        res = XLEN'(sh[7:0]);
        if (sgn && sh[7]) res = res | ~XLEN'(8'hFF);
      end
      2'b01: begin
        res = XLEN'(sh[15:0]);
        if (sgn && sh[15]) res = res | ~XLEN'(16'hFFFF);
      end
      2'b10: begin
        res = XLEN'(sh[31:0]);
        if (sgn && sh[31]) res = res | ~XLEN'(32'hFFFF_FFFF);
      end
      default: res = sh;
    endcase
    return res;
  endfunction

  assign off_in     = address[OFFW-1:0];
  assign base_in    = address & ~XLEN'(NB - 1);
  assign cross_in   = (5'(off_in) + (5'd1 << inst_size)) > 5'(NB);
  assign illegal_in = (mem_read == mem_write) || (XLEN == 32 && inst_size == 2'b11);
  assign rem        = (OFFW + 1)'(NB) - {1'b0, off_q};

  always_comb begin
    ones_in = '0;
    case (inst_size)
      2'b00:   ones_in[0]   = 1'b1;
      2'b01:   ones_in[1:0] = '1;
      2'b10:   ones_in[3:0] = '1;
      default: ones_in[7:0] = '1;
    endcase
    mask_in = ones_in << off_in;
  end

  always_comb begin
    state_d     = state_q;
    mreq_d      = mreq_q;
    write_d     = write_q;
    addr_d      = addr_q;
    byte_en_d   = byte_en_q;
    wr_data_d   = wr_data_q;
    read_data_d = read_data_q;
    err_code_d  = err_code_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    sgn_d       = sgn_q;
    ld_d        = ld_q;
    cross_d     = cross_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf0_d      = buf0_q;
    mask_hi_d   = mask_hi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          off_d     = off_in;
          size_d    = inst_size;
          sgn_d     = is_signed;
          ld_d      = mem_read;
          cross_d   = cross_in;
          base_d    = base_in;
          wdata_d   = write_data;
          mask_hi_d = mask_in[2*NB-1:NB];
          if (illegal_in) begin
            state_d     = RESP;
            err_code_d  = 2'b11;
            read_data_d = '0;
          end else if (cross_in && !ALLOW_MISALIGNED) begin
            state_d     = RESP;
            err_code_d  = 2'b01;
            read_data_d = '0;
          end else begin
            state_d    = BEAT0;
            err_code_d = 2'b00;
            mreq_d     = 1'b1;
            write_d    = mem_write;
            addr_d     = base_in;
            byte_en_d  = mask_in[NB-1:0];
            wr_data_d  = write_data << {off_in, 3'b000};
            cnt_d      = '0;
          end
        end
      end
      BEAT0, BEAT1: begin
        // BEAT1 is entered with mreq low so the bus sees a gap between beats.
        if (state_q == BEAT1 && !mreq_q) begin
          mreq_d = 1'b1;
        end else if (ack) begin
          mreq_d = 1'b0;
          if (state_q == BEAT0) buf0_d = rd_data;
          if (state_q == BEAT0 && cross_q) begin
            state_d   = BEAT1;
            addr_d    = base_q + XLEN'(NB);
            byte_en_d = mask_hi_q;
            wr_data_d = wdata_q >> {rem, 3'b000};
            cnt_d     = '0;
          end else begin
            state_d = RESP;
            if (!ld_q)                read_data_d = '0;
            else if (state_q == BEAT0) read_data_d = load_extend({{XLEN{1'b0}}, rd_data}, off_q, size_q, sgn_q);
            else                      read_data_d = load_extend({rd_data, buf0_q}, off_q, size_q, sgn_q);
          end
        end else if (TO_EN && cnt_q == TO_LAST) begin
          mreq_d      = 1'b0;
          state_d     = RESP;
          err_code_d  = 2'b10;
          read_data_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mreq_q      <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      byte_en_q   <= '0;
      wr_data_q   <= '0;
      read_data_q <= '0;
      err_code_q  <= 2'b00;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      mreq_q      <= mreq_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      byte_en_q   <= byte_en_d;
      wr_data_q   <= wr_data_d;
      read_data_q <= read_data_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
    end
  end

  // Latched operands and first-beat data need no reset: only read while busy.
  always_ff @(posedge clk) begin
    off_q     <= off_d;
    size_q    <= size_d;
    sgn_q     <= sgn_d;
    ld_q      <= ld_d;
    cross_q   <= cross_d;
    base_q    <= base_d;
    wdata_q   <= wdata_d;
    buf0_q    <= buf0_d;
    mask_hi_q <= mask_hi_d;
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign err       = |err_code_q;
  assign err_code  = err_code_q;
  assign read_data = read_data_q;
  assign mreq      = mreq_q;
  assign write     = write_q;
  assign addr      = addr_q;
  assign byte_en   = byte_en_q;
  assign wr_data   = wr_data_q;
endmodule
